// File: rtl/usb_fs_defs.sv
// Shared definitions for the USB full-speed transmit path: line states,
// transmit FSM encoding, stuffer drive modes and CRC16 constants/helper.
package usb_fs_defs;

  // Line states as {p, n}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Transmit FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_EOP  = 2'd3;

  // What the NRZI/stuffer stage drives at a bit strobe
  localparam logic [1:0] DRV_DATA = 2'd0;
  localparam logic [1:0] DRV_SE0  = 2'd1;
  localparam logic [1:0] DRV_J    = 2'd2;

  // CRC16: x^16 + x^15 + x^2 + 1, processed LSB first (reflected form)
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE   = 16'h800D;

  // One byte of reflected CRC16, data LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_fs_nrzi_stuffer.sv
// NRZI encoder with bit stuffing. On each bit strobe it drives either the
// next NRZI level for bit_i (or a stuffed 0 when six ones are pending),
// SE0, or J. Line outputs are registered.
module usb_fs_nrzi_stuffer
  import usb_fs_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_stb_i,
  input  logic [1:0] mode_i,
  input  logic       bit_i,
  output logic       stall_o,
  output logic       p_o,
  output logic       n_o
);

  logic       level_q, level_d;  // 1 = J, 0 = K
  logic [2:0] ones_q, ones_d;
  logic [1:0] line_q, line_d;

  // Six ones on the wire: the next strobe carries a stuffed 0 instead of bit_i
  assign stall_o = (ones_q == 3'd6);
  assign p_o     = line_q[1];
  assign n_o     = line_q[0];

  // Next line level and ones run length for this strobe
  always_comb begin
    level_d = level_q;
    ones_d  = ones_q;
    line_d  = line_q;
    if (bit_stb_i) begin
      case (mode_i)
        DRV_SE0: begin
          level_d = 1'b1;
          ones_d  = 3'd0;
          line_d  = LINE_SE0;
        end
        DRV_J: begin
          level_d = 1'b1;
          ones_d  = 3'd0;
          line_d  = LINE_J;
        end
        default: begin
          if (stall_o || !bit_i) begin
            level_d = !level_q;
            ones_d  = 3'd0;
          end else begin
            ones_d  = ones_q + 3'd1;
          end
          line_d = level_d ? LINE_J : LINE_K;
        end
      endcase
    end
  end

  // Line state registers, idle at J
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      ones_q  <= 3'd0;
      line_q  <= LINE_J;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/usb_fs_tx_phy.sv
// USB full-speed transmit serializer: byte stream in, SYNC / NRZI+stuffing /
// EOP out on usb_p_tx/usb_n_tx with usb_tx_en as pad drive enable.
// Define USB_FS_TX_CRC16_EN to append the data CRC16 after the tx_last byte.
module usb_fs_tx_phy
  import usb_fs_defs::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_BITS    = 8
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int MAXB = (SYNC_BITS > 8) ? SYNC_BITS : 8;
  localparam int IW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] SYNC_END  = IW'(SYNC_BITS);
  localparam logic [IW-1:0] SYNC_LAST = IW'(SYNC_BITS - 1);
  localparam logic [IW-1:0] BYTE_END  = IW'(8);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;       // next bit to send (SYNC/DATA) or EOP bit index
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic          sh_last_q, sh_last_d;
  logic          last_acc_q, last_acc_d;
  logic          discard_q, discard_d;
  logic          en_q, en_d;
  logic          underrun_q, underrun_d;

  logic          accept, bit_wrap, stall, bit_stb, drv_bit;
  logic [1:0]    drv_mode;
  logic          crc_more, pkt_done, nxt_avail, nxt_last;
  logic [7:0]    nxt_byte;

`ifdef USB_FS_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic [1:0]  crc_pend_q, crc_pend_d;
  logic        pid_q, pid_d;
  assign crc_more = (state_q == ST_DATA) && sh_last_q && (crc_pend_q != 2'd0);
  assign nxt_byte = crc_more ? ((crc_pend_q == 2'd2) ? ~crc_q[7:0] : ~crc_q[15:8]) : hold_q;
`else
  assign crc_more = 1'b0;
  assign nxt_byte = hold_q;
`endif

  assign tx_ready    = !hold_full_q && (state_q != ST_EOP) && !last_acc_q;
  assign accept      = tx_valid && tx_ready;
  assign bit_wrap    = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  assign pkt_done    = (state_q == ST_DATA) && sh_last_q && !crc_more;
  assign nxt_avail   = crc_more || hold_full_q;
  assign nxt_last    = crc_more || hold_last_q;
  assign usb_tx_en   = en_q;
  assign tx_busy     = en_q;
  assign tx_underrun = underrun_q;

  // Stream intake, bit timer and per-bit sequencing of SYNC, data and EOP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    sh_last_d   = sh_last_q;
    last_acc_d  = last_acc_q;
    discard_d   = discard_q;
    en_d        = en_q;
    underrun_d  = 1'b0;
    bit_stb     = 1'b0;
    drv_mode    = DRV_DATA;
    drv_bit     = 1'b0;
`ifdef USB_FS_TX_CRC16_EN
    crc_d       = crc_q;
    crc_pend_d  = crc_pend_q;
    pid_d       = pid_q;
`endif

    // Bytes of an aborted packet are swallowed up to and including tx_last
    if (accept) begin
      if (state_q == ST_IDLE && discard_q) begin
        if (tx_last) discard_d = 1'b0;
      end else begin
        hold_d      = tx_data;
        hold_last_d = tx_last;
        hold_full_d = 1'b1;
        if (tx_last) last_acc_d = 1'b1;
      end
    end

    if (state_q == ST_IDLE || bit_wrap) cnt_d = '0;
    else                                cnt_d = cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (accept && !discard_q) begin
          state_d = ST_SYNC;
          en_d    = 1'b1;
          bit_stb = 1'b1;
          drv_bit = (SYNC_BITS == 1);
          idx_d   = IW'(1);
`ifdef USB_FS_TX_CRC16_EN
          crc_d      = CRC16_INIT;
          crc_pend_d = 2'd0;
          pid_d      = 1'b1;
`endif
        end
      end
      ST_SYNC, ST_DATA: begin
        if (bit_wrap) begin
          bit_stb = 1'b1;
          if (stall) begin
            // stuffed 0 goes out; sequencing holds for one bit time
          end else if (state_q == ST_SYNC && idx_q != SYNC_END) begin
            drv_bit = (idx_q == SYNC_LAST);
            idx_d   = idx_q + IW'(1);
          end else if (state_q == ST_DATA && idx_q != BYTE_END) begin
            drv_bit = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + IW'(1);
          end else if (pkt_done) begin
            state_d  = ST_EOP;
            drv_mode = DRV_SE0;
            idx_d    = IW'(1);
          end else if (nxt_avail) begin
            state_d   = ST_DATA;
            drv_bit   = nxt_byte[0];
            shift_d   = {1'b0, nxt_byte[7:1]};
            sh_last_d = nxt_last;
            idx_d     = IW'(1);
            if (!crc_more) hold_full_d = 1'b0;
`ifdef USB_FS_TX_CRC16_EN
            if (crc_more) begin
              crc_pend_d = crc_pend_q - 2'd1;
            end else begin
              if (!pid_q) crc_d = crc16_byte(crc_q, hold_q);
              pid_d = 1'b0;
              if (hold_last_q) crc_pend_d = 2'd2;
            end
`endif
          end else begin
            underrun_d = 1'b1;
            discard_d  = 1'b1;
            state_d    = ST_EOP;
            drv_mode   = DRV_SE0;
            idx_d      = IW'(1);
          end
        end
      end
      ST_EOP: begin
        if (bit_wrap) begin
          bit_stb = 1'b1;
          if (idx_q == IW'(1)) begin
            drv_mode = DRV_SE0;
            idx_d    = IW'(2);
          end else if (idx_q == IW'(2)) begin
            drv_mode = DRV_J;
            idx_d    = IW'(3);
          end else begin
            drv_mode   = DRV_J;
            state_d    = ST_IDLE;
            en_d       = 1'b0;
            last_acc_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      last_acc_q  <= 1'b0;
      discard_q   <= 1'b0;
      en_q        <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef USB_FS_TX_CRC16_EN
      crc_pend_q  <= 2'd0;
      pid_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      last_acc_q  <= last_acc_d;
      discard_q   <= discard_d;
      en_q        <= en_d;
      underrun_q  <= underrun_d;
`ifdef USB_FS_TX_CRC16_EN
      crc_pend_q  <= crc_pend_d;
      pid_q       <= pid_d;
`endif
    end
  end

  // Byte datapath, only meaningful while the control flags say so
  always_ff @(posedge clk_48mhz) begin
    hold_q      <= hold_d;
    hold_last_q <= hold_last_d;
    shift_q     <= shift_d;
    sh_last_q   <= sh_last_d;
`ifdef USB_FS_TX_CRC16_EN
    crc_q       <= crc_d;
`endif
  end

  usb_fs_nrzi_stuffer u_stuffer (
    .clk_i     (clk_48mhz),
    .rst_ni    (reset_n),
    .bit_stb_i (bit_stb),
    .mode_i    (drv_mode),
    .bit_i     (drv_bit),
    .stall_o   (stall),
    .p_o       (usb_p_tx),
    .n_o       (usb_n_tx)
  );

endmodule

// File: tb/tb_usb_fs_tx_phy.sv
// Directed bench for usb_fs_tx_phy: captures one line symbol per bit time
// (J, K, S for SE0) while usb_tx_en is high and compares with hand-derived
// sequences. Build with USB_FS_TX_CRC16_EN to exercise the CRC append.
`timescale 1ns/1ps
module tb_usb_fs_tx_phy;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_last   = 1'b0;
  logic       tx_ready, usb_p_tx, usb_n_tx, usb_tx_en, tx_busy, tx_underrun;

  int    checks   = 0;
  int    failures = 0;
  string cap_s;
  int    cap_cyc, cap_busy_bad, cap_urun_n, cap_urun_at;
  int    idle_bad, en_seen;

  localparam string SYNC = "KJKJKJKK";

  usb_fs_tx_phy #(.CLKS_PER_BIT(4), .SYNC_BITS(8)) dut (
    .clk_48mhz   (clk_48mhz),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .usb_p_tx    (usb_p_tx),
    .usb_n_tx    (usb_n_tx),
    .usb_tx_en   (usb_tx_en),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  function automatic string sym_char(input logic p, input logic n);
    if (p === 1'b1 && n === 1'b0) return "J";
    if (p === 1'b0 && n === 1'b1) return "K";
    if (p === 1'b0 && n === 1'b0) return "S";
    return "X";
  endfunction

  function automatic int max_run(input string s);
    int best = 0;
    int run  = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0 && s[i] == s[i-1]) run++;
      else run = 1;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    tx_last  = l;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk_48mhz);
      n++;
    end
    if (n >= 1000) chk("push_ready_timeout", tx_ready, 1);
    @(negedge clk_48mhz);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic capture();
    int w = 0;
    cap_s = ""; cap_cyc = 0; cap_busy_bad = 0; cap_urun_n = 0; cap_urun_at = -1;
    while (usb_tx_en !== 1'b1 && w < 400) begin
      @(negedge clk_48mhz);
      w++;
    end
    if (usb_tx_en !== 1'b1) begin
      chk("tx_en_rise", usb_tx_en, 1);
      return;
    end
    while (usb_tx_en === 1'b1 && cap_cyc < 2000) begin
      if (cap_cyc % 4 == 0) cap_s = {cap_s, sym_char(usb_p_tx, usb_n_tx)};
      if (tx_busy !== 1'b1) cap_busy_bad++;
      if (tx_underrun === 1'b1) begin
        cap_urun_n++;
        cap_urun_at = cap_cyc;
      end
      cap_cyc++;
      @(negedge clk_48mhz);
    end
  endtask

  task automatic run_a5(input string tag);
    fork
      begin
        push(8'hA5, 1'b1);
        chk({tag, "_ready_after_last"}, tx_ready, 0);
      end
      capture();
    join
    chk_s({tag, "_line"}, cap_s, {SYNC, "KJJKJJKK", "SSJ"});
    chk({tag, "_en_cycles"}, cap_cyc, 76);
    chk({tag, "_busy_gaps"}, cap_busy_bad, 0);
    chk({tag, "_underrun_pulses"}, cap_urun_n, 0);
    @(negedge clk_48mhz);
    chk({tag, "_idle_ready"}, tx_ready, 1);
    chk({tag, "_idle_j"}, {usb_p_tx, usb_n_tx}, 2'b10);
  endtask

  initial begin
    // Reset and idle line
    repeat (3) @(negedge clk_48mhz);
    reset_n = 1'b1;
    idle_bad = 0;
    repeat (50) begin
      @(negedge clk_48mhz);
      if (usb_tx_en !== 1'b0 || usb_p_tx !== 1'b1 || usb_n_tx !== 1'b0 ||
          tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_underrun !== 1'b0) idle_bad++;
    end
    chk("rst_tx_en", usb_tx_en, 0);
    chk("rst_p", usb_p_tx, 1);
    chk("rst_n", usb_n_tx, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("idle_hold_bad_cycles", idle_bad, 0);

`ifdef USB_FS_TX_CRC16_EN
    // PID only: CRC over no bytes is ~FFFF = 0000
    fork
      push(8'hC3, 1'b1);
      capture();
    join
    chk_s("crc_line", cap_s, {SYNC, "KKJKJKKK", "JKJKJKJK", "JKJKJKJK", "SSJ"});
    chk("crc_en_cycles", cap_cyc, 140);
    chk("crc_busy_gaps", cap_busy_bad, 0);
    @(negedge clk_48mhz);
`else
    // Single byte
    run_a5("a5");

    // Two all-ones bytes: two stuffed bits
    fork
      begin
        push(8'hFF, 1'b0);
        push(8'hFF, 1'b1);
      end
      capture();
    join
    chk_s("ff_line", cap_s, {SYNC, "KKKKKJJJJJJJKKKKKK", "SSJ"});
    chk("ff_en_cycles", cap_cyc, 116);
    chk("ff_max_run_le7", (max_run(cap_s) <= 7), 1);
    @(negedge clk_48mhz);

    // Underrun after one byte without tx_last
    fork
      push(8'h2D, 1'b0);
      capture();
    join
    chk_s("urun_line", cap_s, {SYNC, "KJJJKKJK", "SSJ"});
    chk("urun_en_cycles", cap_cyc, 76);
    chk("urun_pulses", cap_urun_n, 1);
    chk("urun_pulse_cycle", cap_urun_at, 64);
    @(negedge clk_48mhz);
    chk("urun_idle_ready", tx_ready, 1);

    // Remainder of the aborted packet is dropped
    push(8'h55, 1'b1);
    en_seen = 0;
    repeat (60) begin
      @(negedge clk_48mhz);
      if (usb_tx_en !== 1'b0) en_seen++;
    end
    chk("discard_no_tx", en_seen, 0);
`endif

    // Reset in the middle of a packet
    push(8'h00, 1'b1);
    repeat (40) @(negedge clk_48mhz);
    chk("mid_pkt_en", usb_tx_en, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_en", usb_tx_en, 0);
    chk("mid_rst_line_j", {usb_p_tx, usb_n_tx}, 2'b10);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(negedge clk_48mhz);

`ifndef USB_FS_TX_CRC16_EN
    run_a5("post_rst");
`else
    chk("post_rst_idle_j", {usb_p_tx, usb_n_tx}, 2'b10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
